attack_phase_fsm: RTL and testbench

Parametrised per-player attack sequencer. Replaces the single-window attack timer with a three-phase attack: startup, active, then recovery. It detects button edges and buffers one attack press so a follow-up can chain. It sits between the controller decode and the hit/animation logic. `hitbox_active` feeds collision, and `anim_state` feeds the sprite row select.

---
 rtl/attack_phase_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_attack_phase_fsm.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/attack_phase_fsm.sv
// Three-phase attack sequencer (startup/active/recovery) with press edge detect and direction decode.
// Optional one-entry press buffer for chaining, enabled by defining ATTACK_BUFFER_EN.
module attack_phase_fsm #(
    parameter int unsigned STARTUP_FRAMES  = 3,
    parameter int unsigned ACTIVE_FRAMES   = 2,
    parameter int unsigned RECOVERY_FRAMES = 4,
    parameter int unsigned BUFFER_FRAMES   = 5,
    parameter int unsigned TIMER_W         = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       btn_atk,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       hit_stun_active,
    output logic       attack_active,
    output logic       hitbox_active,
    output logic [1:0] phase,
    output logic [2:0] attack_type,
    output logic [3:0] anim_state
);

    // state | meaning: IDLE no attack | STARTUP windup | ACTIVE hitbox live | RECOVERY end lag
    typedef enum logic [1:0] {
        PH_IDLE     = 2'd0,
        PH_STARTUP  = 2'd1,
        PH_ACTIVE   = 2'd2,
        PH_RECOVERY = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        AT_NONE    = 3'd0,
        AT_NEUTRAL = 3'd1,
        AT_SIDE    = 3'd2,
        AT_UP      = 3'd3,
        AT_DOWN    = 3'd4
    } atk_e;

    localparam logic [TIMER_W-1:0] ST_LOAD = TIMER_W'(STARTUP_FRAMES - 1);
    localparam logic [TIMER_W-1:0] AC_LOAD = TIMER_W'(ACTIVE_FRAMES - 1);
    localparam logic [TIMER_W-1:0] RC_LOAD = TIMER_W'(RECOVERY_FRAMES - 1);

    phase_e             phase_q, phase_d;
    atk_e               type_q, type_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               prev_q, prev_d;
    logic               act_q, act_d;
    logic               hit_q, hit_d;
    logic [3:0]         anim_q, anim_d;

    logic press;
    atk_e dir_type;
    logic expiring;

`ifdef ATTACK_BUFFER_EN
    // One bit wider than the timer so BUFFER_FRAMES may equal 2^TIMER_W.
    localparam int unsigned       BUF_W    = TIMER_W + 1;
    localparam logic [BUF_W-1:0]  BUF_LOAD = BUF_W'(BUFFER_FRAMES);

    logic [BUF_W-1:0] buf_cnt_q, buf_cnt_d;
    atk_e             buf_type_q, buf_type_d;
`endif

    always_comb begin
        press    = btn_atk & ~prev_q;
        expiring = (phase_q == PH_RECOVERY) && (timer_q == '0);

        if (btn_up)
            dir_type = AT_UP;
        else if (btn_down)
            dir_type = AT_DOWN;
        else if (btn_left || btn_right)
            dir_type = AT_SIDE;
        else
            dir_type = AT_NEUTRAL;
    end

    always_comb begin
        phase_d = phase_q;
        type_d  = type_q;
        timer_d = timer_q;
        prev_d  = prev_q;
`ifdef ATTACK_BUFFER_EN
        buf_cnt_d  = buf_cnt_q;
        buf_type_d = buf_type_q;
`endif

        if (frame_tick) begin
            prev_d = btn_atk;
`ifdef ATTACK_BUFFER_EN
            if (buf_cnt_q != '0)
                buf_cnt_d = buf_cnt_q - BUF_W'(1);
`endif
            if (hit_stun_active) begin
                phase_d = PH_IDLE;
                type_d  = AT_NONE;
                timer_d = '0;
`ifdef ATTACK_BUFFER_EN
                buf_cnt_d  = '0;
                buf_type_d = AT_NONE;
`endif
            end else begin
                case (phase_q)
                    PH_IDLE: begin
                        if (press) begin
                            phase_d = PH_STARTUP;
                            timer_d = ST_LOAD;
                            type_d  = dir_type;
                        end
                    end
                    PH_STARTUP: begin
                        if (timer_q == '0) begin
                            phase_d = PH_ACTIVE;
                            timer_d = AC_LOAD;
                        end else begin
                            timer_d = timer_q - TIMER_W'(1);
                        end
                    end
                    PH_ACTIVE: begin
                        if (timer_q == '0) begin
                            phase_d = PH_RECOVERY;
                            timer_d = RC_LOAD;
                        end else begin
                            timer_d = timer_q - TIMER_W'(1);
                        end
                    end
                    default: begin
                        if (timer_q != '0) begin
                            timer_d = timer_q - TIMER_W'(1);
                        end else if (press) begin
                            // A fresh press on the expiry tick wins over any older buffered one.
                            phase_d = PH_STARTUP;
                            timer_d = ST_LOAD;
                            type_d  = dir_type;
`ifdef ATTACK_BUFFER_EN
                            buf_cnt_d = '0;
                        end else if (buf_cnt_q != '0) begin
                            phase_d   = PH_STARTUP;
                            timer_d   = ST_LOAD;
                            type_d    = buf_type_q;
                            buf_cnt_d = '0;
`endif
                        end else begin
                            phase_d = PH_IDLE;
                            type_d  = AT_NONE;
                            timer_d = '0;
                        end
                    end
                endcase
`ifdef ATTACK_BUFFER_EN
                if (press && (phase_q != PH_IDLE) && !expiring) begin
                    buf_cnt_d  = BUF_LOAD;
                    buf_type_d = dir_type;
                end
`endif
            end
        end

        act_d = (phase_d != PH_IDLE);
        hit_d = (phase_d == PH_ACTIVE);
        case (type_d)
            AT_NEUTRAL: anim_d = 4'd6;
            AT_SIDE:    anim_d = 4'd7;
            AT_UP:      anim_d = 4'd8;
            AT_DOWN:    anim_d = 4'd9;
            default:    anim_d = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= PH_IDLE;
            type_q  <= AT_NONE;
            timer_q <= '0;
            prev_q  <= 1'b0;
            act_q   <= 1'b0;
            hit_q   <= 1'b0;
            anim_q  <= 4'd0;
        end else begin
            phase_q <= phase_d;
            type_q  <= type_d;
            timer_q <= timer_d;
            prev_q  <= prev_d;
            act_q   <= act_d;
            hit_q   <= hit_d;
            anim_q  <= anim_d;
        end
    end

`ifdef ATTACK_BUFFER_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_cnt_q  <= '0;
            buf_type_q <= AT_NONE;
        end else begin
            buf_cnt_q  <= buf_cnt_d;
            buf_type_q <= buf_type_d;
        end
    end
`endif

    assign attack_active = act_q;
    assign hitbox_active = hit_q;
    assign phase         = phase_q;
    assign attack_type   = type_q;
    assign anim_state    = anim_q;

endmodule

// File: tb/tb_attack_phase_fsm.sv
// Scoreboard bench for attack_phase_fsm: directed per-tick vectors, expected phase/type queued per tick.
module tb_attack_phase_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       frame_tick;
    logic       btn_atk, btn_up, btn_down, btn_left, btn_right;
    logic       hit_stun_active;
    logic       attack_active, hitbox_active;
    logic [1:0] phase;
    logic [2:0] attack_type;
    logic [3:0] anim_state;

    typedef struct packed {
        logic [1:0] ph;
        logic [2:0] ty;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    vectors = 0;
    int    miscompares = 0;

    attack_phase_fsm dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .frame_tick      (frame_tick),
        .btn_atk         (btn_atk),
        .btn_up          (btn_up),
        .btn_down        (btn_down),
        .btn_left        (btn_left),
        .btn_right       (btn_right),
        .hit_stun_active (hit_stun_active),
        .attack_active   (attack_active),
        .hitbox_active   (hitbox_active),
        .phase           (phase),
        .attack_type     (attack_type),
        .anim_state      (anim_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int anim_of(input logic [2:0] ty);
        case (ty)
            3'd1:    return 6;
            3'd2:    return 7;
            3'd3:    return 8;
            3'd4:    return 9;
            default: return 0;
        endcase
    endfunction

    // Monitor: after every frame tick edge, pop the expected state and compare all outputs.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge clk);
            if (frame_tick && reset_n) begin
                #1;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL scoreboard: tick with no expected entry, phase=%0d", phase);
                end else begin
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    check({n, " phase"}, int'(phase), int'(e.ph));
                    check({n, " type"}, int'(attack_type), int'(e.ty));
                    check({n, " attack_active"}, int'(attack_active), int'(e.ph != 2'd0));
                    check({n, " hitbox_active"}, int'(hitbox_active), int'(e.ph == 2'd2));
                    check({n, " anim_state"}, int'(anim_state), anim_of(e.ty));
                end
            end
        end
    end

    task automatic set_dir(input byte c);
        btn_up    = (c == "u") || (c == "x");
        btn_down  = (c == "d") || (c == "y");
        btn_left  = (c == "l") || (c == "x");
        btn_right = (c == "r") || (c == "y");
    endtask

    // One character per tick. atk/stun: '0'/'1'; dir: n u d l r x(up+left) y(down+right).
    // ph/ty: expected phase and type after that tick. Short stimulus strings pad with 0/n.
    task automatic scen(input string name, input string atk, input string dir,
                        input string stun, input string ph, input string ty);
        exp_t item;
        for (int i = 0; i < ph.len(); i++) begin
            @(negedge clk);
            btn_atk         = (i < atk.len()) ? (atk[i] == "1") : 1'b0;
            hit_stun_active = (i < stun.len()) ? (stun[i] == "1") : 1'b0;
            set_dir((i < dir.len()) ? dir[i] : "n");
            frame_tick = 1'b1;
            item.ph = 2'(ph[i] - 8'd48);
            item.ty = 3'(ty[i] - 8'd48);
            exp_q.push_back(item);
            name_q.push_back($sformatf("%s t%0d", name, i));
            @(negedge clk);
            frame_tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, " phase"}, int'(phase), 0);
        check({name, " type"}, int'(attack_type), 0);
        check({name, " attack_active"}, int'(attack_active), 0);
        check({name, " hitbox_active"}, int'(hitbox_active), 0);
        check({name, " anim_state"}, int'(anim_state), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        frame_tick = 1'b0;
        btn_atk = 1'b0;
        hit_stun_active = 1'b0;
        set_dir("n");
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        scen("neutral", "1", "", "", "111223333000", "111111111000");
        scen("held", "11111111111111111111", "", "",
             "11122333300000000000000", "11111111100000000000000");
        scen("priority", "1", "xxxxxxxxxxxx", "", "111223333000", "333333333000");
`ifdef ATTACK_BUFFER_EN
        scen("chain", "10000001", "nnnnnnny", "",
             "111223333111223333000", "111111111444444444000");
`else
        scen("chain", "10000001", "nnnnnnny", "",
             "111223333000000000000", "111111111000000000000");
`endif
        scen("expiry", "101", "nnu", "", "111223333000", "111111111000");
        scen("expiry_press", "1000000001", "nnnnnnnnnl", "",
             "111223333111223333000", "111111111222222222000");
        scen("stun", "100101", "", "000011", "1112000000000", "1111000000000");

        // Leave btn_atk high into reset so the post-reset press depends on btn_atk_prev clearing.
        scen("pre_reset", "100001", "", "", "111223", "111111");
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        scen("post_reset", "1", "d", "", "111223333000", "444444444000");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
        end
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
